// File: rtl/fb_pkg.sv
// Shared types and defaults for the frame-buffer arbiter.
// The write-entry widths fix the width of the FIFO storage. The top-level
// ADDR_WIDTH/DATA_WIDTH defaults are taken from them.
package fb_pkg;

    localparam int FB_ADDR_WIDTH   = 32;
    localparam int FB_DATA_WIDTH   = 32;
    localparam int FB_FRAME_WIDTH  = 320;
    localparam int FB_FRAME_HEIGHT = 240;

    typedef logic [23:0] pixel_t;

    typedef struct packed {
        logic [FB_ADDR_WIDTH-1:0] addr;
        logic [FB_DATA_WIDTH-1:0] data;
    } fb_wr_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        BLANK_READ,
        WRITE
    } arb_state_e;

endpackage

// File: rtl/fb_wfifo.sv
// In-order write FIFO of fb_wr_t entries, pointer-compare full/empty.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: a push while full is ignored, and so is a pop while empty.
// Ports: clk/n_rst, push_i+push_dat_i, pop_i, head_dat_o, full_o, empty_o.
module fb_wfifo
    import fb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   n_rst,
    input  logic   push_i,
    input  fb_wr_t push_dat_i,
    input  logic   pop_i,
    output fb_wr_t head_dat_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

    // The extra MSB is the wrap bit. It separates full from empty when the index bits match.
    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    fb_wr_t         store_q [DEPTH];

    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign full_o     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head_dat_o = store_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i && !full_o) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_i && !empty_o) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // The storage needs no reset because the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push_i && !full_o) begin
            store_q[wr_ptr_q[PTR_W-1:0]] <= push_dat_i;
        end
    end

endmodule

// File: rtl/frame_buffer_arbiter.sv
// Shares a single-port frame buffer between buffered AHB writes and VGA pixel reads.
// Latency: mem_* is combinational in the winning cycle. rd_valid/rd_pixel arrive 2 cycles after rd_req.
// Backpressure: reads always win. Writes wait in the FIFO. wr_ready=!full, and a refused or out-of-frame write pulses wr_drop.
// Ports: AHB write side (wr_*), VGA read side (rd_req, x/y_coordinate, rd_valid, rd_pixel), memory side (mem_*), wfifo_empty.
module frame_buffer_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_WIDTH   = FB_ADDR_WIDTH,
    parameter int DATA_WIDTH   = FB_DATA_WIDTH,
    parameter int FRAME_WIDTH  = FB_FRAME_WIDTH,
    parameter int FRAME_HEIGHT = FB_FRAME_HEIGHT,
    parameter int WFIFO_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    output logic                  wr_drop,
    input  logic                  rd_req,
    input  logic [9:0]            x_coordinate,
    input  logic [9:0]            y_coordinate,
    output logic                  rd_valid,
    output logic [23:0]           rd_pixel,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  wfifo_empty
);

    localparam int                    FRAME_SIZE   = FRAME_WIDTH * FRAME_HEIGHT;
    localparam logic [ADDR_WIDTH-1:0] FRAME_SIZE_A = ADDR_WIDTH'(FRAME_SIZE);
    localparam logic [10:0]           FRAME_W_C    = 11'(FRAME_WIDTH);
    localparam logic [10:0]           FRAME_H_C    = 11'(FRAME_HEIGHT);

    fb_wr_t     push_dat;
    fb_wr_t     head_dat;
    logic       fifo_full;
    logic       fifo_empty;
    logic       push;
    logic       pop;
    logic       wr_in_frame;
    logic       rd_in_frame;
    arb_state_e arb_state;

    logic       s1_vld_q,   s1_vld_d;
    logic       s1_blank_q, s1_blank_d;
    logic       rd_valid_q, rd_valid_d;
    pixel_t     rd_pixel_q, rd_pixel_d;

    // ---------------- write intake ----------------
    assign wr_in_frame = (wr_addr < FRAME_SIZE_A);
    // Gating on n_rst keeps the combinational outputs quiet while reset is asserted.
    assign push        = n_rst && wr_req && !fifo_full && wr_in_frame;
    assign wr_drop     = n_rst && wr_req && (fifo_full || !wr_in_frame);
    assign wr_ready    = !fifo_full;
    assign wfifo_empty = fifo_empty;
    assign push_dat    = '{addr: wr_addr, data: wr_data};

    fb_wfifo #(
        .DEPTH (WFIFO_DEPTH)
    ) u_wfifo (
        .clk        (clk),
        .n_rst      (n_rst),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .head_dat_o (head_dat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    // ---------------- per-cycle arbitration ----------------
    assign rd_in_frame = ({1'b0, x_coordinate} < FRAME_W_C) &&
                         ({1'b0, y_coordinate} < FRAME_H_C);

    always_comb begin
        arb_state = IDLE;
        if (!n_rst) begin
            arb_state = IDLE;
        end else if (rd_req) begin
            arb_state = rd_in_frame ? READ : BLANK_READ;
        end else if (!fifo_empty) begin
            // fifo_empty is registered, so an entry pushed this cycle cannot drain until the next one.
            arb_state = WRITE;
        end
    end

    assign pop = (arb_state == WRITE);

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (arb_state)
            READ: begin
                mem_en   = 1'b1;
                mem_addr = ADDR_WIDTH'(y_coordinate) * ADDR_WIDTH'(FRAME_WIDTH)
                         + ADDR_WIDTH'(x_coordinate);
            end
            WRITE: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = head_dat.addr;
                mem_wdata = head_dat.data;
            end
            default: ;
        endcase
    end

    // ---------------- read return pipeline ----------------
    // Stage 1 lines up with the memory's one-cycle read data. Stage 2 registers the pixel.
    always_comb begin
        s1_vld_d   = (arb_state == READ) || (arb_state == BLANK_READ);
        s1_blank_d = (arb_state == BLANK_READ);
        rd_valid_d = s1_vld_q;
        rd_pixel_d = rd_pixel_q;
        if (s1_vld_q) begin
            rd_pixel_d = s1_blank_q ? '0 : mem_rdata[23:0];
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1_vld_q   <= 1'b0;
            s1_blank_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_pixel_q <= '0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_blank_q <= s1_blank_d;
            rd_valid_q <= rd_valid_d;
            rd_pixel_q <= rd_pixel_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_pixel = rd_pixel_q;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Self-checking bench for frame_buffer_arbiter: directed scenarios, then random traffic.
// Latency: the reference expects pixels 2 cycles after rd_req and writes to memory in acceptance order.
// Backpressure: the reference tracks FIFO occupancy, so it knows when wr_ready and wr_drop should change.
module tb_frame_buffer_arbiter;

    localparam int FW    = 320;
    localparam int FH    = 240;
    localparam int FS    = FW * FH;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        wr_req;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        wr_drop;
    logic        rd_req;
    logic [9:0]  x_coordinate;
    logic [9:0]  y_coordinate;
    logic        rd_valid;
    logic [23:0] rd_pixel;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        wfifo_empty;

    always #5 clk = ~clk;

    frame_buffer_arbiter dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .wr_drop      (wr_drop),
        .rd_req       (rd_req),
        .x_coordinate (x_coordinate),
        .y_coordinate (y_coordinate),
        .rd_valid     (rd_valid),
        .rd_pixel     (rd_pixel),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .wfifo_empty  (wfifo_empty)
    );

    // Single-port SRAM behind the DUT. Read data appears one cycle after issue.
    logic [31:0] sram   [FS];
    logic [31:0] refmem [FS];

    always @(posedge clk) begin
        if (mem_en && mem_addr < FS) begin
            if (mem_we) sram[mem_addr[16:0]] <= mem_wdata;
            else        mem_rdata <= sram[mem_addr[16:0]];
        end
    end

    // Reference model: a queue of pending writes, an image of memory, and a 2-deep list of expected returns.
    typedef struct {
        int unsigned addr;
        logic [31:0] data;
    } wr_t;

    wr_t         pend[$];
    bit          pv1, pv2;
    logic [23:0] pp1, pp2;

    int n_checks = 0;
    int n_errors = 0;

    logic        obs_mem_en, obs_mem_we, obs_wr_drop, obs_wr_ready, obs_rd_valid, obs_empty;
    logic [31:0] obs_mem_addr;
    logic [23:0] obs_rd_pixel;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive the inputs, check at the negedge against the model, then advance the model.
    task automatic step(input bit rq, input int x, input int y,
                        input bit wq, input int unsigned wa, input logic [31:0] wd);
        bit          full, in_rd, exp_write, acc;
        int unsigned ra;
        rd_req       = rq;
        x_coordinate = 10'(x);
        y_coordinate = 10'(y);
        wr_req       = wq;
        wr_addr      = wa;
        wr_data      = wd;
        @(negedge clk);
        obs_mem_en   = mem_en;
        obs_mem_we   = mem_we;
        obs_mem_addr = mem_addr;
        obs_wr_drop  = wr_drop;
        obs_wr_ready = wr_ready;
        obs_rd_valid = rd_valid;
        obs_rd_pixel = rd_pixel;
        obs_empty    = wfifo_empty;

        full      = (pend.size() >= DEPTH);
        in_rd     = (x < FW) && (y < FH);
        ra        = in_rd ? int'(y * FW + x) : 0;
        exp_write = !rq && (pend.size() > 0);
        acc       = wq && !full && (wa < FS);

        check_eq("wr_ready", wr_ready, !full);
        check_eq("wfifo_empty", wfifo_empty, pend.size() == 0);
        check_eq("wr_drop", wr_drop, wq && !acc);
        check_eq("rd_valid", rd_valid, pv2);
        if (pv2) check_eq("rd_pixel", rd_pixel, pp2);
        if (rq && in_rd) begin
            check_eq("rd_mem_en", mem_en, 1);
            check_eq("rd_mem_we", mem_we, 0);
            check_eq("rd_mem_addr", mem_addr, ra);
        end else if (rq) begin
            check_eq("blank_mem_en", mem_en, 0);
        end else if (exp_write) begin
            check_eq("wr_mem_en", mem_en, 1);
            check_eq("wr_mem_we", mem_we, 1);
            check_eq("wr_mem_addr", mem_addr, pend[0].addr);
            check_eq("wr_mem_wdata", mem_wdata, pend[0].data);
        end else begin
            check_eq("idle_mem_en", mem_en, 0);
            check_eq("idle_mem_we", mem_we, 0);
            check_eq("idle_mem_addr", mem_addr, 0);
            check_eq("idle_mem_wdata", mem_wdata, 0);
        end

        pv2 = pv1;
        pp2 = pp1;
        pv1 = rq;
        pp1 = (rq && in_rd) ? refmem[ra][23:0] : 24'h0;
        if (exp_write) begin
            refmem[pend[0].addr] = pend[0].data;
            void'(pend.pop_front());
        end
        if (acc) pend.push_back('{wa, wd});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    // Asserts reset away from the clock edge, checks the reset values, then releases.
    task automatic apply_reset(input string tag);
        n_rst        = 1'b0;
        rd_req       = 1'b0;
        wr_req       = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        x_coordinate = '0;
        y_coordinate = '0;
        #2;
        check_eq({tag, "_wr_ready"}, wr_ready, 1);
        check_eq({tag, "_wfifo_empty"}, wfifo_empty, 1);
        check_eq({tag, "_wr_drop"}, wr_drop, 0);
        check_eq({tag, "_rd_valid"}, rd_valid, 0);
        check_eq({tag, "_rd_pixel"}, rd_pixel, 0);
        check_eq({tag, "_mem_en"}, mem_en, 0);
        check_eq({tag, "_mem_we"}, mem_we, 0);
        check_eq({tag, "_mem_addr"}, mem_addr, 0);
        check_eq({tag, "_mem_wdata"}, mem_wdata, 0);
        @(negedge clk);
        #2 n_rst = 1'b1;
        @(posedge clk);
        #1;
        pend.delete();
        pv1 = 0;
        pv2 = 0;
        pp1 = '0;
        pp2 = '0;
    endtask

    initial begin
        int unsigned wa;
        for (int i = 0; i < FS; i++) begin
            sram[i]   = $urandom;
            refmem[i] = sram[i];
        end
        sram[645]   = 32'hAB123456;
        refmem[645] = 32'hAB123456;
        mem_rdata   = '0;

        apply_reset("rst");

        // In-frame read: x=5, y=2 gives address 645.
        step(1, 5, 2, 0, 0, 0);
        check_eq("rd645_addr", obs_mem_addr, 645);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check_eq("rd645_valid", obs_rd_valid, 1);
        check_eq("rd645_pixel", obs_rd_pixel, 24'h123456);

        // Out-of-frame column returns a black pixel and does not touch memory.
        step(1, 320, 0, 0, 0, 0);
        check_eq("blank_en", obs_mem_en, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check_eq("blank_valid", obs_rd_valid, 1);
        check_eq("blank_pixel", obs_rd_pixel, 0);

        // Fill the FIFO while reads hold the memory. The fifth write is dropped.
        for (int i = 0; i < 5; i++) step(1, 10, 10, 1, i, 32'hC0DE0000 + i);
        check_eq("fill_drop", obs_wr_drop, 1);
        check_eq("fill_ready", obs_wr_ready, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0, 0);
            check_eq("drain_we", obs_mem_we, 1);
            check_eq("drain_addr", obs_mem_addr, i);
        end
        idle(2);

        // Frame boundary on the write side.
        step(0, 0, 0, 1, FS, 32'h11111111);
        check_eq("oob_drop", obs_wr_drop, 1);
        step(0, 0, 0, 0, 0, 0);
        check_eq("oob_empty", obs_empty, 1);
        step(0, 0, 0, 1, FS - 1, 32'h22222222);
        check_eq("last_drop", obs_wr_drop, 0);
        idle(3);

        // Alternating reads with two queued writes.
        step(1, 7, 3, 1, 100, 32'hAAAA0001);
        step(1, 8, 3, 1, 101, 32'hAAAA0002);
        for (int k = 0; k < 8; k++) step(k % 2 == 1, 9 + k, 4, 0, 0, 0);
        idle(3);

        // Reset mid-drain with three entries queued and a read in flight.
        for (int i = 0; i < 4; i++) step(1, 20 + i, 5, 1, 200 + i, 32'hBEEF0000 + i);
        step(0, 0, 0, 0, 0, 0);
        apply_reset("mid_rst");
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0, 0);
            check_eq("post_rst_en", obs_mem_en, 0);
        end

        // Random traffic with bursty reads and occasional out-of-frame coordinates and addresses.
        for (int i = 0; i < 1500; i++) begin
            bit rq;
            rq = (i % 200 < 30) ? 1'b1 : ($urandom_range(0, 99) < 45);
            wa = ($urandom_range(0, 9) == 0) ? FS + $urandom_range(0, 40)
                                             : $urandom_range(0, FS - 1);
            step(rq, $urandom_range(0, 335), $urandom_range(0, 250),
                 $urandom_range(0, 99) < 55, wa, $urandom);
        end
        idle(DEPTH + 3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
